// File: rtl/rtoc_ctrl_pkg.sv
// rtoc_ctrl_pkg: shared state type and word layout for the RTOC write scheduler
package rtoc_ctrl_pkg;
  typedef enum logic [1:0] {STOPPED, RUNNING, FLUSHING} rtoc_state_t;
  localparam int RTOC_WORD_W = 128;
  localparam int RTOC_TS_MSB = 127;
  localparam int RTOC_TS_LSB = 64;
endpackage

// File: rtl/rtoc_rr_arbiter.sv
// rtoc_rr_arbiter: combinational round-robin pick of the first set req at or above ptr, with wrap-around
module rtoc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);
  always_comb begin
    grant_idx = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % NUM_REQ]) begin
        grant_idx = IW'((int'(ptr) + k) % NUM_REQ);
        grant_valid = 1'b1;
      end
    end
    grant = grant_valid ? NUM_REQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/rtoc_write_scheduler.sv
// rtoc_write_scheduler: round-robin FIFO write-port arbiter plus run/stop/flush sequencer for one RTOC core
module rtoc_write_scheduler
  import rtoc_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLUSH_CYCLES = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(FLUSH_CYCLES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [RTOC_WORD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           start_cmd,
  input  logic                           stop_cmd,
  input  logic                           flush_cmd,
  input  logic                           core_full,
  output logic                           core_write,
  output logic [RTOC_WORD_W-1:0]         core_din,
  output logic                           core_flush,
  output logic                           core_auto_start,
  output logic                           busy,
  output logic [IW-1:0]                  grant_id
);
  rtoc_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] ptr, g;
  logic gv, eligible;
  assign eligible = state != FLUSHING && !flush_cmd && !core_full;
  assign busy = state == FLUSHING;
  rtoc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .en(eligible),
    .grant(req_ready),
    .grant_idx(g),
    .grant_valid(gv)
  );
  always_comb begin
    state_n = flush_cmd ? FLUSHING
            : state == FLUSHING ? (cnt == '0 ? STOPPED : FLUSHING)
            : stop_cmd ? STOPPED
            : start_cmd ? RUNNING
            : state;
    cnt_n = flush_cmd ? CW'(FLUSH_CYCLES - 1) : state == FLUSHING ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STOPPED;
      cnt <= '0;
      ptr <= '0;
      core_write <= 1'b0;
      core_din <= '0;
      core_flush <= 1'b0;
      core_auto_start <= 1'b0;
      grant_id <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      core_flush <= state_n == FLUSHING;
      core_auto_start <= state_n == RUNNING;
      core_write <= gv;
      if (gv) begin
        ptr <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
        core_din <= req_data[g*RTOC_WORD_W +: RTOC_WORD_W];
        grant_id <= g;
      end
    end
  end
endmodule
